// File: rtl/uart_rx_sampler_if.sv
// Serial receive port bundle: the rx pin plus the decoded byte and status strobes.
// The receiver takes the master modport; the application or pin side takes slave.
interface uart_rx_sampler_if;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;
  logic       busy;

  modport master (input rx, output data, rcv, ferr, busy);
  modport slave  (output rx, input data, rcv, ferr, busy);
endinterface

// File: rtl/uart_rx_sampler.sv
// UART 8N1 receiver: synchronises rx, validates the start bit at half period,
// samples each data bit mid-period and strobes rcv (good stop) or ferr (bad stop).
module uart_rx_sampler #(
  parameter int BAUDRATE = 1250
) (
  input  logic clk,
  input  logic rstn,
  uart_rx_sampler_if.master uart
);

  localparam int HALF = BAUDRATE / 2;
  localparam int CW   = $clog2(BAUDRATE);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUDRATE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic          sync1, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    data_q, data_n;
  logic          rcv_q, rcv_n;
  logic          ferr_q, ferr_n;
  logic          busy_q, busy_n;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      rcv_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1   <= uart.rx;
      rx_s    <= sync1;
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      data_q  <= data_n;
      rcv_q   <= rcv_n;
      ferr_q  <= ferr_n;
      busy_q  <= busy_n;
    end
  end

  // Counter restarts on every transition and on every bit boundary inside DATA.
  always_comb begin
    state_n   = state;
    cnt_n     = '0;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    data_n    = data_q;
    rcv_n     = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_n = START;
      end
      START: begin
        cnt_n = cnt + 1'b1;
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        cnt_n = cnt + 1'b1;
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            rcv_n   = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      // A held break must return high before another start bit is believed.
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  assign uart.data = data_q;
  assign uart.rcv  = rcv_q;
  assign uart.ferr = ferr_q;
  assign uart.busy = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Randomised scoreboard bench for uart_rx_sampler at 16 and 32 cycles per bit,
// with a waveform-level reference model predicting every rcv/ferr strobe.
module tb_uart_rx_sampler;

  localparam int BA = 16;
  localparam int BB = 32;

  typedef bit wave_t[$];
  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    int         cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_rx_sampler_if if_a ();
  uart_rx_sampler_if if_b ();

  uart_rx_sampler #(.BAUDRATE(BA)) dut_a (.clk(clk), .rstn(rstn), .uart(if_a));
  uart_rx_sampler #(.BAUDRATE(BB)) dut_b (.clk(clk), .rstn(rstn), .uart(if_b));

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] last_good_a = 8'h00;
  logic [7:0] last_good_b = 8'h00;
  int         cycle = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         count_en = 1'b0;
  int         busy_cnt_a = 0;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (!count_en) busy_cnt_a = 0;
    else if (if_a.busy) busy_cnt_a = busy_cnt_a + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cycle);
    end
  endtask

  function automatic wave_t cat(input wave_t a, input wave_t b);
    wave_t r;
    r = a;
    foreach (b[i]) r.push_back(b[i]);
    return r;
  endfunction

  function automatic wave_t fill(input int n, input bit v);
    wave_t r;
    for (int i = 0; i < n; i++) r.push_back(v);
    return r;
  endfunction

  function automatic wave_t frame(input logic [7:0] d, input bit stop, input int bitlen);
    wave_t r;
    for (int b = 0; b < 10; b++) begin
      bit v;
      v = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
      for (int c = 0; c < bitlen; c++) r.push_back(v);
    end
    return r;
  endfunction

  function automatic bit at_(input wave_t w, input int i);
    return (i < w.size()) ? w[i] : 1'b1;
  endfunction

  // Line value sampled at edge base+i is w[i]; the receiver sees it two edges later.
  task automatic predict(input wave_t w, input int base, input int baud, input bit on_b);
    int half;
    int pos;
    int p;
    int s;
    int q;
    logic [7:0] lg;
    logic [7:0] d;
    exp_t e;
    half = baud / 2;
    pos  = 0;
    lg   = on_b ? last_good_b : last_good_a;
    forever begin
      p = pos;
      while (p < w.size() && w[p]) p++;
      if (p >= w.size()) break;
      if (at_(w, p + half)) begin
        pos = p + half + 1;
        continue;
      end
      for (int i = 0; i < 8; i++) d[i] = at_(w, p + half + (i + 1) * baud);
      s = p + half + 9 * baud;
      e.is_ferr = !at_(w, s);
      e.cycle   = base + s + 2;
      if (!e.is_ferr) begin
        e.data = d;
        lg     = d;
        pos    = s + 1;
      end else begin
        e.data = lg;
        q = s + 1;
        while (!at_(w, q)) q++;
        pos = q + 1;
      end
      if (on_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
    if (on_b) last_good_b = lg;
    else      last_good_a = lg;
  endtask

  task automatic applyStimulus(input wave_t w, input bit on_b, input int baud, input bit do_predict);
    int base;
    @(posedge clk);
    #1;
    base = cycle + 1;
    if (do_predict) predict(w, base, baud, on_b);
    foreach (w[i]) begin
      if (on_b) if_b.rx = w[i];
      else      if_a.rx = w[i];
      @(posedge clk);
      #1;
    end
    if (on_b) if_b.rx = 1'b1;
    else      if_a.rx = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if_a.rcv || if_a.ferr) begin
      checkOutput("a_rcv_ferr_exclusive", int'(if_a.rcv & if_a.ferr), 0);
      if (q_a.size() == 0) begin
        checkOutput("a_unexpected_pulse", 1, 0);
      end else begin
        e = q_a.pop_front();
        checkOutput("a_pulse_is_ferr", int'(if_a.ferr), int'(e.is_ferr));
        checkOutput("a_data", int'(if_a.data), int'(e.data));
        checkOutput("a_pulse_cycle", cycle, e.cycle);
        checkOutput("a_busy_at_pulse", int'(if_a.busy), int'(e.is_ferr));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if_b.rcv || if_b.ferr) begin
      checkOutput("b_rcv_ferr_exclusive", int'(if_b.rcv & if_b.ferr), 0);
      if (q_b.size() == 0) begin
        checkOutput("b_unexpected_pulse", 1, 0);
      end else begin
        e = q_b.pop_front();
        checkOutput("b_pulse_is_ferr", int'(if_b.ferr), int'(e.is_ferr));
        checkOutput("b_data", int'(if_b.data), int'(e.data));
        checkOutput("b_pulse_cycle", cycle, e.cycle);
        checkOutput("b_busy_at_pulse", int'(if_b.busy), int'(e.is_ferr));
      end
    end
  end

  initial begin
    wave_t w;
    int    r;
    bit    stop;
    if_a.rx = 1'b1;
    if_b.rx = 1'b1;
    rstn    = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_data", int'(if_a.data), 0);
    checkOutput("reset_rcv", int'(if_a.rcv), 0);
    checkOutput("reset_ferr", int'(if_a.ferr), 0);
    checkOutput("reset_busy", int'(if_a.busy), 0);
    checkOutput("reset_data_b", int'(if_b.data), 0);
    rstn = 1'b1;
    repeat (4) @(posedge clk);

    $display("[TB] single frame 0x55");
    applyStimulus(frame(8'h55, 1'b1, BA), 1'b0, BA, 1'b1);
    repeat (40) @(posedge clk);

    $display("[TB] back-to-back 0xA3, 0x0F");
    applyStimulus(cat(frame(8'hA3, 1'b1, BA), frame(8'h0F, 1'b1, BA)), 1'b0, BA, 1'b1);
    repeat (40) @(posedge clk);

    $display("[TB] three-cycle glitch");
    count_en = 1'b1;
    applyStimulus(fill(3, 1'b0), 1'b0, BA, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch_busy_cycles", busy_cnt_a, 8);
    checkOutput("glitch_data_kept", int'(if_a.data), 8'h0F);
    count_en = 1'b0;

    $display("[TB] framing error with held break, then 0x81");
    w = cat(frame(8'h3C, 1'b0, BA), fill(40, 1'b0));
    w = cat(w, fill(20, 1'b1));
    w = cat(w, frame(8'h81, 1'b1, BA));
    applyStimulus(w, 1'b0, BA, 1'b1);
    repeat (40) @(posedge clk);

    $display("[TB] reset during data bit 4 of 0xC6");
    w = frame(8'hC6, 1'b1, BA);
    w = w[0:(4 * BA + BA / 2) - 1];
    applyStimulus(w, 1'b0, BA, 1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    last_good_a = 8'h00;
    @(negedge clk);
    checkOutput("midframe_reset_data", int'(if_a.data), 0);
    checkOutput("midframe_reset_busy", int'(if_a.busy), 0);
    repeat (20) @(posedge clk);
    applyStimulus(frame(8'hC6, 1'b1, BA), 1'b0, BA, 1'b1);
    repeat (40) @(posedge clk);

    $display("[TB] 33 cycles/bit sender into 32 cycles/bit receiver, 0xE7");
    applyStimulus(frame(8'hE7, 1'b1, 33), 1'b1, BB, 1'b1);
    repeat (60) @(posedge clk);

    $display("[TB] randomised traffic");
    w = fill(4, 1'b1);
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        w = cat(w, fill($urandom_range(1, BA / 2 - 1), 1'b0));
        w = cat(w, fill(BA / 2 + 2, 1'b1));
      end else begin
        stop = ($urandom_range(0, 7) != 0);
        w = cat(w, frame(8'($urandom_range(0, 255)), stop, BA));
        if (!stop) w = cat(w, fill($urandom_range(0, 30), 1'b0));
        w = cat(w, fill($urandom_range(0, 20), 1'b1));
      end
    end
    applyStimulus(w, 1'b0, BA, 1'b1);
    repeat (60) @(posedge clk);

    checkOutput("a_all_expected_seen", q_a.size(), 0);
    checkOutput("b_all_expected_seen", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
